bp_me_mem_cmd_arbiter: RTL and testbench
========================================

# bp_me_mem_cmd_arbiter

Shares one BedRock memory command/response channel pair among `num_req_p` cache engines, for example the I$ UCE and the D$ UCE in front of `bp_nonsynth_mem`. Commands are granted round-robin, and the grant stays locked until the memory accepts the command. Each accepted command records its requester ID in an in-order tracking FIFO, which routes every memory response back to the requester that issued it. The block sits between the cache engines and the memory or tracer, on the single `clk_i` domain.

## Interface
Parameters:
- `num_req_p`, 2, number of requesters; must be ≥2.
- `msg_width_p`, 128, width of the packed `bp_bedrock_cce_mem_msg_s` (header plus data); the payload is opaque to this block.
- `max_outstanding_p`, 4, depth of the tracking FIFO, i.e. the maximum number of accepted commands still awaiting a response.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `cmd_i`  in  num_req_p*msg_width_p  per-requester command.
- `cmd_v_i`  in  num_req_p  per-requester command valid.
- `cmd_ready_o`  out  num_req_p  per-requester ready; a command transfers when valid and ready are both high.
- `mem_cmd_o`  out  msg_width_p  granted command.
- `mem_cmd_v_o`  out  1  command valid to memory.
- `mem_cmd_ready_i`  in  1  memory ready; a command transfers when valid and ready are both high.
- `mem_resp_i`  in  msg_width_p  memory response.
- `mem_resp_v_i`  in  1  memory response valid.
- `mem_resp_yumi_o`  out  1  response consumed.
- `resp_o`  out  msg_width_p  `mem_resp_i` broadcast to all requesters.
- `resp_v_o`  out  num_req_p  one-hot response valid.
- `resp_yumi_i`  in  num_req_p  per-requester response consume.

## Operation
State machine, 2 states:
- **e_arb:**
  - When the FIFO is not full and some `cmd_v_i` is high, pick the first valid requester at or after `rr_ptr_r`, wrapping modulo `num_req_p`.
  - Drive `mem_cmd_o` and `mem_cmd_v_o` combinationally from the winner.
  - If `mem_cmd_ready_i` is high, the transfer completes this cycle: raise the winner's `cmd_ready_o`, push the winner ID, and set `rr_ptr_r` to winner+1 mod `num_req_p`.
  - Otherwise latch the winner into `gnt_r` and go to e_hold.
- **e_hold:**
  - Present requester `gnt_r` only; no re-arbitration takes place.
  - On `mem_cmd_ready_i`, transfer, push, advance `rr_ptr_r` past `gnt_r`, and go to e_arb.
- Requesters must hold `cmd_v_i` and `cmd_i` stable until ready; this is a bench assertion.

Response path:
- `resp_v_o[head_id]` = `mem_resp_v_i` & ~empty; all other bits are 0.
- `mem_resp_yumi_o` = `resp_yumi_i[head_id]` & `resp_v_o[head_id]`.
- Pop the FIFO on `mem_resp_yumi_o`.

Boundaries:
- **FIFO full:** no grant is made; `mem_cmd_v_o` = 0 in e_arb. Pending requests wait; they are not dropped.
- **e_hold when full:** cannot occur, because entry into e_hold requires not full and no push happens while in hold.
- **Push and pop in the same cycle:** both happen and the count is unchanged. A pop in cycle N does not free a slot for a grant in cycle N; the full check uses the registered count.
- **`mem_resp_v_i` with the FIFO empty:** this is an error. `mem_resp_yumi_o` = 0 and an assertion fires.
- **Reset mid-operation:**
  - State returns to e_arb, `rr_ptr_r` = 0, and the FIFO empties.
  - In-flight responses are lost; memory must be reset together with this block.

## Timing
- Reset values:
  - `mem_cmd_v_o` = 0, `cmd_ready_o` = 0, `resp_v_o` = 0, `mem_resp_yumi_o` = 0.
  - State e_arb, `rr_ptr_r` = 0, FIFO count = 0.
- Command path has 0-cycle latency: a valid requester with the memory ready transfers in the same cycle.
- Response path has 0-cycle latency: `mem_resp_v_i` reaches `resp_v_o` combinationally.
- All `*_ready_o` and `*_v_o` outputs depend only on registered state and current inputs. There is no combinational loop from `cmd_ready_o` to `cmd_v_i`.
- Throughput is 1 command per cycle while the FIFO is not full and the memory is ready.

## Configuration
Macro: `BP_ME_MEM_ARB_STATS_EN`.
- **Defined:**
  - Adds per-requester 32-bit saturating counters: grants, and stall cycles (valid high but not granted).
  - Adds a cycle counter of FIFO-full stalls.
  - Counters clear on reset and print via `$display` in a `final` block.
- **Undefined:** no counters and no extra logic. Port list and behaviour are identical in both builds.

## Structure
- Shared package `bp_me_pkg` holds:
  - typedef `bp_me_mem_arb_state_e` {`e_arb`, `e_hold`};
  - localparam helper `req_id_width` = `$clog2(num_req_p)`.
- The tracking FIFO is a natural sub-module: use `bsg_fifo_1r1w_small` with width = req_id_width and els = `max_outstanding_p`.
- Round-robin selection is inline logic.

## Test plan
1. **Single requester.** Req0 sends A with memory ready → A appears on `mem_cmd_o` in the same cycle, and req0's ready is high for 1 cycle. The response is then routed to `resp_v_o` = 2'b01.
2. **Contention.** Both requesters are valid continuously from reset with memory always ready → grants alternate 0,1,0,1 across 4 cycles, and responses return in the order 0,1,0,1 with matching one-hot `resp_v_o`.
3. **Hold.** Req1 is granted while `mem_cmd_ready_i` = 0 for 3 cycles and req0 asserts valid mid-hold → `mem_cmd_o` stays req1's command. Req1 transfers on cycle 4, and req0 is granted on cycle 5.
4. **Full.** `max_outstanding_p` = 4 and 4 commands are accepted with no responses → the 5th is held with `mem_cmd_v_o` = 0. One response yumi frees a slot, and the 5th is granted the following cycle.
5. **Response backpressure.** The head response is for req1 and `resp_yumi_i[1]` = 0 for 2 cycles → `mem_resp_yumi_o` = 0 and there is no pop. Yumi on cycle 3 pops the FIFO.
6. **Reset mid-operation.** Reset is asserted with 2 outstanding and the FSM in e_hold → all outputs are 0 immediately (asynchronous), and after deassertion the count = 0, the state is e_arb, and `rr_ptr_r` = 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the BedRock memory-command arbiter.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_arb  = 1'b0,
    e_hold = 1'b1
  } bp_me_mem_arb_state_e;

  function automatic int req_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with ready/valid enqueue and valid/yumi dequeue.
// ready_o depends only on the registered count.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               enq, deq;

  assign ready_o = (count_q != cnt_w'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock mem cmd/resp pair among num_req_p engines.
// Optional statistics counters under BP_ME_MEM_ARB_STATS_EN.
//   state  | meaning
//   e_arb  | pick next valid requester round-robin; transfer if memory ready
//   e_hold | grant locked on gnt_q until memory accepts
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]             cmd_v_i,
  output logic [num_req_p-1:0]             cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i
);

  localparam int id_w = req_id_width(num_req_p);

  bp_me_mem_arb_state_e state_q;
  logic [id_w-1:0] rr_ptr_q, gnt_q;
  logic [id_w-1:0] win_id, idx, sel_id, next_ptr, head_id;
  logic            win_found, sel_v, cmd_fire, resp_ok;
  logic            fifo_ready, fifo_v;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_w'((int'(rr_ptr_q) + i) % num_req_p);
      if (!win_found && cmd_v_i[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    sel_id      = (state_q == e_hold) ? gnt_q : win_id;
    sel_v       = (state_q == e_hold) ? cmd_v_i[gnt_q] : (win_found & fifo_ready);
    mem_cmd_v_o = sel_v & ~reset_i;
    cmd_fire    = mem_cmd_v_o & mem_cmd_ready_i;
    mem_cmd_o   = cmd_i[sel_id*msg_width_p +: msg_width_p];
    next_ptr    = (sel_id == id_w'(num_req_p - 1)) ? '0 : sel_id + 1'b1;
    cmd_ready_o = '0;
    if (cmd_fire) cmd_ready_o[sel_id] = 1'b1;
  end

  always_comb begin
    resp_ok          = mem_resp_v_i & fifo_v & ~reset_i;
    resp_v_o         = '0;
    resp_v_o[head_id] = resp_ok;
    mem_resp_yumi_o  = resp_ok & resp_yumi_i[head_id];
  end

  assign resp_o = mem_resp_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_arb;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      case (state_q)
        e_arb: if (sel_v) begin
          if (cmd_fire) begin
            rr_ptr_q <= next_ptr;
          end else begin
            gnt_q   <= win_id;
            state_q <= e_hold;
          end
        end
        e_hold: if (cmd_fire) begin
          rr_ptr_q <= next_ptr;
          state_q  <= e_arb;
        end
        default: state_q <= e_arb;
      endcase
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p(id_w),
    .els_p  (max_outstanding_p)
  ) tracker (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (cmd_fire),
    .ready_o(fifo_ready),
    .data_i (sel_id),
    .v_o    (fifo_v),
    .data_o (head_id),
    .yumi_i (mem_resp_yumi_o)
  );

`ifndef SYNTHESIS
  resp_without_cmd: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_v_i && !fifo_v));
`endif

`ifdef BP_ME_MEM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [num_req_p];
  logic [31:0] stall_cnt_q [num_req_p];
  logic [31:0] full_stall_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_req_p; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
      full_stall_q <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (cmd_ready_o[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
        if (cmd_v_i[i] && !cmd_ready_o[i] && stall_cnt_q[i] != '1)
          stall_cnt_q[i] <= stall_cnt_q[i] + 1'b1;
      end
      if (state_q == e_arb && !fifo_ready && |cmd_v_i && full_stall_q != '1)
        full_stall_q <= full_stall_q + 1'b1;
    end
  end

  final begin
    for (int i = 0; i < num_req_p; i++)
      $display("mem_cmd_arb req%0d grants=%0d stalls=%0d", i, grant_cnt_q[i], stall_cnt_q[i]);
    $display("mem_cmd_arb full_stalls=%0d", full_stall_q);
  end
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed bench for bp_me_mem_cmd_arbiter (2 requesters, 128-bit messages, depth 4).
module tb_bp_me_mem_cmd_arbiter;

  localparam int N = 2;
  localparam int W = 128;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] cmd_i;
  logic [N-1:0]   cmd_v_i;
  logic [N-1:0]   cmd_ready_o;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  logic [W-1:0]   resp_o;
  logic [N-1:0]   resp_v_o;
  logic [N-1:0]   resp_yumi_i;

  int n_chk = 0;
  int n_err = 0;

  bp_me_mem_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .cmd_i          (cmd_i),
    .cmd_v_i        (cmd_v_i),
    .cmd_ready_o    (cmd_ready_o),
    .mem_cmd_o      (mem_cmd_o),
    .mem_cmd_v_o    (mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i     (mem_resp_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .resp_o         (resp_o),
    .resp_v_o       (resp_v_o),
    .resp_yumi_i    (resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [W-1:0] v);
    cmd_i[r*W +: W] = v;
  endtask

  // A stalled requester must keep valid and payload stable until ready.
  logic [N-1:0]   stall_q = '0;
  logic [N*W-1:0] cmd_prev = '0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      stall_q = '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (stall_q[r]) begin
          chk_eq("hold_v", W'(cmd_v_i[r]), W'(1));
          chk_eq("hold_cmd", cmd_i[r*W +: W], cmd_prev[r*W +: W]);
        end
      end
      stall_q  = cmd_v_i & ~cmd_ready_o;
      cmd_prev = cmd_i;
    end
  end

  initial begin
    reset_i         = 1'b1;
    cmd_i           = '0;
    cmd_v_i         = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i      = '0;
    mem_resp_v_i    = 1'b1;
    resp_yumi_i     = 2'b11;
    #2;
    chk_eq("rst_mem_cmd_v", W'(mem_cmd_v_o), W'(0));
    chk_eq("rst_cmd_ready", W'(cmd_ready_o), W'(0));
    chk_eq("rst_resp_v", W'(resp_v_o), W'(0));
    chk_eq("rst_resp_yumi", W'(mem_resp_yumi_o), W'(0));
    tick(); tick();
    reset_i = 1'b0; cmd_v_i = '0; mem_resp_v_i = 1'b0; resp_yumi_i = '0; mem_cmd_ready_i = 1'b0;

    // single requester
    set_cmd(0, 128'hA0A0); cmd_v_i = 2'b01; mem_cmd_ready_i = 1'b1;
    #1;
    chk_eq("t1_v", W'(mem_cmd_v_o), W'(1));
    chk_eq("t1_cmd", mem_cmd_o, 128'hA0A0);
    chk_eq("t1_rdy", W'(cmd_ready_o), W'(2'b01));
    tick();
    cmd_v_i = '0;
    #1;
    chk_eq("t1_rdy_off", W'(cmd_ready_o), W'(0));
    chk_eq("t1_v_off", W'(mem_cmd_v_o), W'(0));
    mem_resp_v_i = 1'b1; mem_resp_i = 128'hFACE; resp_yumi_i = 2'b01;
    #1;
    chk_eq("t1_resp_v", W'(resp_v_o), W'(2'b01));
    chk_eq("t1_resp_o", resp_o, 128'hFACE);
    chk_eq("t1_yumi", W'(mem_resp_yumi_o), W'(1));
    tick();
    mem_resp_v_i = 1'b0; resp_yumi_i = '0;
    #1;
    chk_eq("t1_resp_idle", W'(resp_v_o), W'(0));

    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;

    // contention from reset, then fill to the limit
    set_cmd(0, 128'hB0); set_cmd(1, 128'hB1); cmd_v_i = 2'b11; mem_cmd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_eq("t2_rdy", W'(cmd_ready_o), (k % 2 == 1) ? W'(2'b10) : W'(2'b01));
      chk_eq("t2_cmd", mem_cmd_o, (k % 2 == 1) ? 128'hB1 : 128'hB0);
      tick();
    end
    cmd_v_i = 2'b01;
    #1;
    chk_eq("t4_full_v", W'(mem_cmd_v_o), W'(0));
    chk_eq("t4_full_rdy", W'(cmd_ready_o), W'(0));
    tick();
    mem_resp_v_i = 1'b1; mem_resp_i = 128'h5E5; resp_yumi_i = 2'b11;
    #1;
    chk_eq("t2_resp0", W'(resp_v_o), W'(2'b01));
    chk_eq("t2_yumi0", W'(mem_resp_yumi_o), W'(1));
    chk_eq("t4_pop_same_cyc_v", W'(mem_cmd_v_o), W'(0));
    tick();
    #1;
    chk_eq("t2_resp1", W'(resp_v_o), W'(2'b10));
    chk_eq("t4_freed_v", W'(mem_cmd_v_o), W'(1));
    chk_eq("t4_freed_rdy", W'(cmd_ready_o), W'(2'b01));
    tick();
    cmd_v_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_eq("t2_resp_tail", W'(resp_v_o), (k == 1) ? W'(2'b10) : W'(2'b01));
      chk_eq("t2_yumi_tail", W'(mem_resp_yumi_o), W'(1));
      tick();
    end
    mem_resp_v_i = 1'b0; resp_yumi_i = '0;
    #1;
    chk_eq("t2_drained", W'(resp_v_o), W'(0));

    // hold: req1 locked while memory stalls, req0 arrives mid-hold
    set_cmd(1, 128'hC1); cmd_v_i = 2'b10; mem_cmd_ready_i = 1'b0;
    #1;
    chk_eq("t3_h0_v", W'(mem_cmd_v_o), W'(1));
    chk_eq("t3_h0_cmd", mem_cmd_o, 128'hC1);
    chk_eq("t3_h0_rdy", W'(cmd_ready_o), W'(0));
    tick();
    set_cmd(0, 128'hC0); cmd_v_i = 2'b11;
    for (int h = 1; h < 3; h++) begin
      #1;
      chk_eq("t3_hold_cmd", mem_cmd_o, 128'hC1);
      chk_eq("t3_hold_rdy", W'(cmd_ready_o), W'(0));
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    chk_eq("t3_h3_cmd", mem_cmd_o, 128'hC1);
    chk_eq("t3_h3_rdy", W'(cmd_ready_o), W'(2'b10));
    tick();
    cmd_v_i = 2'b01;
    #1;
    chk_eq("t3_h4_cmd", mem_cmd_o, 128'hC0);
    chk_eq("t3_h4_rdy", W'(cmd_ready_o), W'(2'b01));
    tick();
    cmd_v_i = '0; mem_cmd_ready_i = 1'b0;

    // response backpressure on head (req1)
    mem_resp_v_i = 1'b1; mem_resp_i = 128'hD1; resp_yumi_i = 2'b01;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_eq("t5_bp_resp_v", W'(resp_v_o), W'(2'b10));
      chk_eq("t5_bp_yumi", W'(mem_resp_yumi_o), W'(0));
      tick();
    end
    resp_yumi_i = 2'b10;
    #1;
    chk_eq("t5_pop_resp_v", W'(resp_v_o), W'(2'b10));
    chk_eq("t5_pop_yumi", W'(mem_resp_yumi_o), W'(1));
    tick();
    resp_yumi_i = 2'b01;
    #1;
    chk_eq("t5_next_resp_v", W'(resp_v_o), W'(2'b01));
    chk_eq("t5_next_yumi", W'(mem_resp_yumi_o), W'(1));
    tick();
    mem_resp_v_i = 1'b0; resp_yumi_i = '0;
    #1;
    chk_eq("t5_empty", W'(resp_v_o), W'(0));

    // reset with two outstanding and the FSM holding req1
    set_cmd(1, 128'hE1); cmd_v_i = 2'b10; mem_cmd_ready_i = 1'b1;
    tick();
    set_cmd(0, 128'hE0); cmd_v_i = 2'b01;
    tick();
    set_cmd(1, 128'hE2); cmd_v_i = 2'b10; mem_cmd_ready_i = 1'b0;
    #1;
    chk_eq("t6_pre_cmd", mem_cmd_o, 128'hE2);
    tick();
    #1;
    chk_eq("t6_hold_v", W'(mem_cmd_v_o), W'(1));
    mem_cmd_ready_i = 1'b1; mem_resp_v_i = 1'b1; resp_yumi_i = 2'b11; reset_i = 1'b1;
    #1;
    chk_eq("t6_rst_mem_cmd_v", W'(mem_cmd_v_o), W'(0));
    chk_eq("t6_rst_cmd_ready", W'(cmd_ready_o), W'(0));
    chk_eq("t6_rst_resp_v", W'(resp_v_o), W'(0));
    chk_eq("t6_rst_resp_yumi", W'(mem_resp_yumi_o), W'(0));
    tick();
    reset_i = 1'b0; mem_resp_v_i = 1'b0; resp_yumi_i = '0;
    set_cmd(0, 128'hF0); set_cmd(1, 128'hF1); cmd_v_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_eq("t6_post_rdy", W'(cmd_ready_o), (k % 2 == 1) ? W'(2'b10) : W'(2'b01));
      tick();
    end
    #1;
    chk_eq("t6_post_full_v", W'(mem_cmd_v_o), W'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
